edge_detect_gen: RTL and testbench

- Parametrised, frame-synchronous 3x3 edge detector for the video processing (VP) chain. It takes one greyscale pixel per enabled clock and sits after greyscale conversion, ahead of the overlay/binarisation consumers.
- Successor block: it generalises pixel width, has internal line buffers, and supports Sobel/Prewitt/Scharr kernels and L1/L2 norms.
- Emits a saturated gradient magnitude, an edge flag, and border masking. Mode and threshold are latched per frame.

---
 rtl/edge_detect_gen.sv | 245 ++++++++++++++++++++++++
 tb/tb_edge_detect_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/edge_detect_gen.sv
// ---------------------------------------------------------------------------
// edge_detect_gen
// Frame-synchronous 3x3 gradient edge detector for the video chain. One
// greyscale pixel per pre_de cycle. Two internal line buffers feed a 3x3
// window, and Sobel/Prewitt/Scharr kernels (mode) produce |Gx| and |Gy|.
// A saturated magnitude and an edge flag are emitted five clocks after the
// input. The output for input (col,row) is the window centred at
// (col-1,row-1). Outputs are masked to zero when col<2 or row<2.
// EN, mode and threshold are captured on each pre_vs rising edge. EN=0
// selects a plain binarise bypass.
//
// Ports
//   clk        pixel clock
//   rst_n      asynchronous active-low reset
//   EN         1 = edge detect, 0 = binarise bypass (latched per frame)
//   mode       0 Sobel, 1 Prewitt, 2 Scharr, 3 Sobel (latched per frame)
//   threshold  edge / binarise threshold (latched per frame)
//   pre_vs     input vertical sync
//   pre_de     input data enable
//   pre_data   input pixel
//   post_vs    pre_vs delayed 5 clocks
//   post_de    pre_de delayed 5 clocks
//   post_bit   edge flag
//   post_mag   saturated gradient magnitude (or bypassed pixel)
// ---------------------------------------------------------------------------
module edge_detect_gen #(
  parameter int DATA_W    = 8,
  parameter int IMG_HDISP = 1280,
  parameter int IMG_VDISP = 720,
  parameter int NORM      = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              EN,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] threshold,
  input  logic              pre_vs,
  input  logic              pre_de,
  input  logic [DATA_W-1:0] pre_data,
  output logic              post_vs,
  output logic              post_de,
  output logic              post_bit,
  output logic [DATA_W-1:0] post_mag
);

  localparam int GW    = DATA_W + 4;
  localparam int MW    = DATA_W + 5;
  localparam int SQW   = 2 * GW + 1;
  localparam int COL_W = (IMG_HDISP > 4) ? $clog2(IMG_HDISP) : 2;
  localparam int ROW_W = (IMG_VDISP > 4) ? $clog2(IMG_VDISP) : 2;

  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_HDISP - 1);
  localparam logic [COL_W-1:0]  COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMG_VDISP - 1);
  localparam logic [ROW_W-1:0]  ROW_TWO  = ROW_W'(2);
  localparam logic [DATA_W-1:0] PIX_MAX  = '1;

  typedef struct packed {
    logic              vs;
    logic              mask;
    logic              byp;
    logic              byp_bit;
    logic [DATA_W-1:0] data;
  } side_t;

  // Packed kernel weights {outer, centre}; the reserved code falls back to Sobel.
  function automatic logic [7:0] kern_w(input logic [1:0] m);
    case (m)
      2'd1:    return {4'd1, 4'd1};
      2'd2:    return {4'd3, 4'd10};
      default: return {4'd1, 4'd2};
    endcase
  endfunction

  function automatic logic [GW-1:0] wsum(input logic [7:0] k,
                                         input logic [DATA_W-1:0] a,
                                         input logic [DATA_W-1:0] b,
                                         input logic [DATA_W-1:0] c);
    logic [GW-1:0] ko, kc;
    ko = GW'(k[7:4]);
    kc = GW'(k[3:0]);
    return ko * GW'(a) + kc * GW'(b) + ko * GW'(c);
  endfunction

  function automatic logic [GW-1:0] abs_diff(input logic [GW-1:0] p,
                                             input logic [GW-1:0] n);
    return (p >= n) ? p - n : n - p;
  endfunction

  function automatic logic [DATA_W-1:0] sat_pix(input logic [MW-1:0] v);
    return (v > MW'(PIX_MAX)) ? PIX_MAX : v[DATA_W-1:0];
  endfunction

  // Frame control: sync edges, counters, per-frame configuration
  logic                vs_d, de_d, armed, en_f;
  logic [1:0]          mode_f;
  logic [DATA_W-1:0]   thr_f;
  logic [2*DATA_W-1:0] thr_sq_f;
  logic [COL_W-1:0]    col;
  logic [ROW_W-1:0]    row;
  logic                vs_rise, de_fall;

  assign vs_rise = pre_vs & ~vs_d;
  assign de_fall = de_d & ~pre_de;

  // armed stays low after reset until a frame start is seen, so a frame
  // interrupted by reset produces only zero outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d     <= 1'b0;
      de_d     <= 1'b0;
      armed    <= 1'b0;
      en_f     <= 1'b0;
      mode_f   <= '0;
      thr_f    <= '0;
      thr_sq_f <= '0;
      col      <= '0;
      row      <= '0;
    end else begin
      vs_d <= pre_vs;
      de_d <= pre_de;
      if (vs_rise) begin
        armed    <= 1'b1;
        en_f     <= EN;
        mode_f   <= mode;
        thr_f    <= threshold;
        thr_sq_f <= (2*DATA_W)'(threshold) * (2*DATA_W)'(threshold);
      end
      if (pre_de) col <= (col == COL_LAST) ? col : col + 1'b1;
      else        col <= '0;
      if (vs_rise)                                   row <= '0;
      else if (de_fall && armed && row != ROW_LAST) row <= row + 1'b1;
    end
  end

  // Line buffers: lb1 holds row-1, lb2 holds row-2 at the current column
  logic [DATA_W-1:0] lb1 [IMG_HDISP];
  logic [DATA_W-1:0] lb2 [IMG_HDISP];
  logic [DATA_W-1:0] up1, up2;

  assign up1 = lb1[col];
  assign up2 = lb2[col];

  always_ff @(posedge clk) begin
    if (pre_de) begin
      lb1[col] <= pre_data;
      lb2[col] <= up1;
    end
  end

  side_t      side_in;
  logic [7:0] kw;

  assign kw = kern_w(mode_f);

  always_comb begin
    side_in         = '0;
    side_in.vs      = pre_vs;
    side_in.mask    = ~armed | (en_f & ((col < COL_TWO) | (row < ROW_TWO)));
    side_in.byp     = ~en_f;
    side_in.byp_bit = (pre_data >= thr_f);
    side_in.data    = pre_data;
  end

  // Window columns: index 0 is col-2, index 2 is col; top is row-2, bot is row
  logic [2:0][DATA_W-1:0] top_p1, mid_p1, bot_p1;
  logic [GW-1:0]          gx_pos_p2, gx_neg_p2, gy_pos_p2, gy_neg_p2;
  logic [GW-1:0]          gx_abs_p3, gy_abs_p3;
  logic [MW-1:0]          l1_p4;
  logic [SQW-1:0]         sq_p4;
  side_t                  side_p1, side_p2, side_p3, side_p4;
  logic                   vld_p1, vld_p2, vld_p3, vld_p4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_p1    <= '0;
      mid_p1    <= '0;
      bot_p1    <= '0;
      gx_pos_p2 <= '0;
      gx_neg_p2 <= '0;
      gy_pos_p2 <= '0;
      gy_neg_p2 <= '0;
      gx_abs_p3 <= '0;
      gy_abs_p3 <= '0;
      l1_p4     <= '0;
      sq_p4     <= '0;
      side_p1   <= '0;
      side_p2   <= '0;
      side_p3   <= '0;
      side_p4   <= '0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      vld_p3    <= 1'b0;
      vld_p4    <= 1'b0;
      post_vs   <= 1'b0;
      post_de   <= 1'b0;
      post_bit  <= 1'b0;
      post_mag  <= '0;
    end else begin
      // S1: window shift, advances only on valid pixels
      if (pre_de) begin
        top_p1 <= {up2,      top_p1[2:1]};
        mid_p1 <= {up1,      mid_p1[2:1]};
        bot_p1 <= {pre_data, bot_p1[2:1]};
      end
      side_p1 <= side_in;
      vld_p1  <= pre_de;

      // S2: unsigned positive/negative weighted sums
      gx_pos_p2 <= wsum(kw, top_p1[2], mid_p1[2], bot_p1[2]);
      gx_neg_p2 <= wsum(kw, top_p1[0], mid_p1[0], bot_p1[0]);
      gy_pos_p2 <= wsum(kw, bot_p1[0], bot_p1[1], bot_p1[2]);
      gy_neg_p2 <= wsum(kw, top_p1[0], top_p1[1], top_p1[2]);
      side_p2   <= side_p1;
      vld_p2    <= vld_p1;

      // S3: absolute gradients by compare-and-subtract
      gx_abs_p3 <= abs_diff(gx_pos_p2, gx_neg_p2);
      gy_abs_p3 <= abs_diff(gy_pos_p2, gy_neg_p2);
      side_p3   <= side_p2;
      vld_p3    <= vld_p2;

      // S4: L1 sum always (it drives post_mag), squared norm for NORM=1
      l1_p4   <= MW'(gx_abs_p3) + MW'(gy_abs_p3);
      sq_p4   <= SQW'(gx_abs_p3) * SQW'(gx_abs_p3) + SQW'(gy_abs_p3) * SQW'(gy_abs_p3);
      side_p4 <= side_p3;
      vld_p4  <= vld_p3;

      // S5: threshold compare, saturation, masking and bypass select
      post_vs <= side_p4.vs;
      post_de <= vld_p4;
      if (!vld_p4 || side_p4.mask) begin
        post_bit <= 1'b0;
        post_mag <= '0;
      end else if (side_p4.byp) begin
        post_bit <= side_p4.byp_bit;
        post_mag <= side_p4.data;
      end else begin
        post_bit <= (NORM != 0) ? (sq_p4 >= SQW'(thr_sq_f)) : (l1_p4 >= MW'(thr_f));
        post_mag <= sat_pix(l1_p4);
      end
    end
  end

endmodule

// File: tb/tb_edge_detect_gen.sv
module tb_edge_detect_gen;
  localparam int DW   = 8;
  localparam int H    = 8;
  localparam int V    = 6;
  localparam int NORM = 0;
  localparam int LAT  = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          EN = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [DW-1:0] threshold = '0;
  logic          pre_vs = 1'b0;
  logic          pre_de = 1'b0;
  logic [DW-1:0] pre_data = '0;
  logic          post_vs, post_de, post_bit;
  logic [DW-1:0] post_mag;

  edge_detect_gen #(
    .DATA_W(DW), .IMG_HDISP(H), .IMG_VDISP(V), .NORM(NORM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .EN(EN), .mode(mode), .threshold(threshold),
    .pre_vs(pre_vs), .pre_de(pre_de), .pre_data(pre_data),
    .post_vs(post_vs), .post_de(post_de), .post_bit(post_bit), .post_mag(post_mag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int mag; int bt; int cyc; } exp_t;
  exp_t exp_q[$];
  int   vs_q[$];

  // Reference model state: the image as written so far plus frame config
  int img [V][H];
  bit m_armed = 1'b0;
  bit m_en    = 1'b0;
  int m_mode  = 0;
  int m_thr   = 0;
  bit vs_prev = 1'b0;
  int rst_cnt = 0;
  bit done    = 1'b0;
  int n_chk   = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Direct 3x3 convolution on the stored image, centred at (c-1, r-1)
  function automatic void ref_pixel(input int c, input int r, input int d,
                                    output int m, output int b);
    int wo, wc, gx, gy, l1;
    m = 0;
    b = 0;
    if (!m_armed) return;
    if (!m_en) begin
      m = d;
      b = (d >= m_thr) ? 1 : 0;
      return;
    end
    if (c < 2 || r < 2) return;
    wo = (m_mode == 2) ? 3 : 1;
    wc = (m_mode == 1) ? 1 : (m_mode == 2) ? 10 : 2;
    gx = wo * (img[r-2][c] - img[r-2][c-2]) + wc * (img[r-1][c] - img[r-1][c-2])
       + wo * (img[r][c]   - img[r][c-2]);
    gy = wo * (img[r][c-2] - img[r-2][c-2]) + wc * (img[r][c-1] - img[r-2][c-1])
       + wo * (img[r][c]   - img[r-2][c]);
    l1 = iabs(gx) + iabs(gy);
    m  = (l1 > 255) ? 255 : l1;
    if (NORM != 0) b = (gx * gx + gy * gy >= m_thr * m_thr) ? 1 : 0;
    else           b = (l1 >= m_thr) ? 1 : 0;
  endfunction

  function automatic int pix(input int kind, input int c, input int r);
    case (kind)
      0:       return 100;
      1:       return (c >= 4) ? 20 : 0;
      2:       return ((r * H + c) * 255) / (H * V - 1);
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  // One clock of stimulus; ar asserts reset for three clocks at this point.
  task automatic tick(input bit vs, input bit de, input int d,
                      input int c, input int r, input bit ar);
    exp_t e;
    int   m, b;
    @(posedge clk);
    #1;
    if (rst_cnt > 0) begin
      rst_cnt--;
      if (rst_cnt == 0) rst_n = 1'b1;
    end
    if (ar) begin
      rst_n   = 1'b0;
      rst_cnt = 3;
      exp_q.delete();
      vs_q.delete();
      m_armed = 1'b0;
      vs_prev = 1'b0;
    end
    pre_vs   = vs;
    pre_de   = de;
    pre_data = DW'(d);
    if (vs && !vs_prev) begin
      m_armed = 1'b1;
      m_en    = EN;
      m_mode  = int'(mode);
      m_thr   = int'(threshold);
      vs_q.push_back(cyc);
    end
    vs_prev = vs;
    if (de) begin
      img[r][c] = d;
      if (rst_n) begin
        ref_pixel(c, r, d, m, b);
        e.mag = m;
        e.bt  = b;
        e.cyc = cyc;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic send_frame(input int kind, input bit en, input int md, input int thr,
                            input int chg_row, input int chg_md, input int chg_thr,
                            input int rst_row, input int rst_col);
    EN        = en;
    mode      = 2'(md);
    threshold = DW'(thr);
    repeat (2) tick(0, 0, 0, 0, 0, 0);
    repeat ($urandom_range(1, 3)) tick(1, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    for (int r = 0; r < V; r++) begin
      if (r == chg_row) begin
        mode      = 2'(chg_md);
        threshold = DW'(chg_thr);
      end
      for (int c = 0; c < H; c++)
        tick(0, 1, pix(kind, c, r), c, r, (r == rst_row) && (c == rst_col));
      repeat ($urandom_range(1, 4)) tick(0, 0, 0, 0, 0, 0);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a pixel
  initial begin
    bit   vs_seen;
    bit   ok;
    exp_t e;
    vs_seen = 1'b0;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        #1;
        chk("rst_post_vs",  int'(post_vs),  0);
        chk("rst_post_de",  int'(post_de),  0);
        chk("rst_post_bit", int'(post_bit), 0);
        chk("rst_post_mag", int'(post_mag), 0);
        vs_seen = 1'b0;
      end else begin
        if (post_vs && !vs_seen) begin
          ok = (vs_q.size() != 0);
          chk("vs_expected", int'(ok), 1);
          if (ok) chk("vs_latency", cyc - vs_q.pop_front(), LAT);
        end
        vs_seen = post_vs;
        if (post_de) begin
          ok = (exp_q.size() != 0);
          chk("de_expected", int'(ok), 1);
          if (ok) begin
            e = exp_q.pop_front();
            chk("post_mag",   int'(post_mag), e.mag);
            chk("post_bit",   int'(post_bit), e.bt);
            chk("de_latency", cyc - e.cyc,    LAT);
          end
        end else begin
          chk("idle_mag", int'(post_mag), 0);
          chk("idle_bit", int'(post_bit), 0);
        end
        if (done) begin
          chk("pending_pixels", exp_q.size(), 0);
          chk("pending_vs",     vs_q.size(),  0);
          $display("%0d/%0d checks passed", n_pass, n_chk);
          $finish;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    // flat field, then the vertical step under each kernel
    send_frame(0, 1, 0, 1,   -1, 0, 0, -1, -1);
    send_frame(1, 1, 0, 70,  -1, 0, 0, -1, -1);
    send_frame(1, 1, 1, 70,  -1, 0, 0, -1, -1);
    send_frame(1, 1, 2, 70,  -1, 0, 0, -1, -1);
    // bypass ramp
    send_frame(2, 0, 0, 128, -1, 0, 0, -1, -1);
    // mid-frame config change applies to the following frame only
    send_frame(1, 1, 0, 70,   3, 3, 90, -1, -1);
    send_frame(1, 1, 3, 90,  -1, 0, 0, -1, -1);
    // reset mid-line, then a clean repeat of the step frame
    send_frame(1, 1, 0, 70,  -1, 0, 0, 2, 4);
    send_frame(1, 1, 0, 70,  -1, 0, 0, -1, -1);
    // random content and configuration (first one with threshold 0)
    for (int f = 0; f < 8; f++) begin
      int md, thr;
      bit en;
      en  = ($urandom_range(0, 3) != 0);
      md  = int'($urandom_range(0, 3));
      thr = (f == 0) ? 0 : int'($urandom_range(0, 255));
      send_frame(3, en, md, thr, -1, 0, 0, -1, -1);
    end
    repeat (LAT + 4) tick(0, 0, 0, 0, 0, 0);
    done = 1'b1;
  end

endmodule
